// File: rtl/alu_seq8.sv
// -----------------------------------------------------------------------------
// alu_seq8 -- nibble-serial 8-bit ALU sequencer for the 6502 datapath.
//
// Accepts one 8-bit request and runs it through a single shared 4-bit alu4
// slice over successive cycles: low nibble, optional decimal adjust, high
// nibble, optional decimal adjust. The inter-nibble carry is formed from the
// slice's G/P outputs. The 8-bit result and 6502-style C/V/N/Z flags are
// returned under a start/busy/done handshake.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-high reset
//   start          : request strobe, accepted only in IDLE
//   op[2:0]        : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5..7 PASSA
//   dec            : decimal mode, honoured for ADD only
//   a, b [7:0]     : operands
//   ci             : carry in (for SUB, 1 = no borrow)
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse in DONE
//   result[7:0]    : result, held until the next completed operation
//   c_out/v_out/n_out/z_out : flags, held with result
//   alu_a/alu_b[3:0], alu_s[3:0], alu_m, alu_ci : slice drive
//   alu_f[3:0], alu_g, alu_p                    : slice response
// -----------------------------------------------------------------------------
module alu_seq8 #(
  parameter logic [3:0] S_ADD   = 4'b1001,
  parameter logic [3:0] S_SUB   = 4'b0110,
  parameter logic [3:0] S_AND   = 4'b1011,
  parameter logic [3:0] S_OR    = 4'b1110,
  parameter logic [3:0] S_XOR   = 4'b0110,
  parameter logic [3:0] S_PASSA = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       dec,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       v_out,
  output logic       n_out,
  output logic       z_out,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_s,
  output logic       alu_m,
  output logic       alu_ci,
  input  logic [3:0] alu_f,
  input  logic       alu_g,
  input  logic       alu_p
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_LOADJ,
    ST_HI,
    ST_HIADJ,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       ci_q, ci_d;
  logic [2:0] op_q, op_d;
  logic       dec_q, dec_d;
  logic [7:0] r_q, r_d;          // working result, nibble by nibble
  logic       c_lo_q, c_lo_d;    // carry from low nibble into high nibble
  logic       c_hi_q, c_hi_d;    // carry out of high nibble
  logic       v_q, v_d;          // overflow captured from the binary high pass
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       c_out_q, c_out_d;
  logic       v_out_q, v_out_d;
  logic       n_out_q, n_out_d;
  logic       z_out_q, z_out_d;

  // ---------------------------------------------------------------------------
  // Operation decode from the registered request
  // ---------------------------------------------------------------------------
  logic       is_arith;
  logic       is_dec_add;
  logic [3:0] op_sel;

  always_comb begin
    is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    is_dec_add = dec_q && (op_q == OP_ADD);
    case (op_q)
      OP_ADD:  op_sel = S_ADD;
      OP_SUB:  op_sel = S_SUB;
      OP_AND:  op_sel = S_AND;
      OP_OR:   op_sel = S_OR;
      OP_XOR:  op_sel = S_XOR;
      default: op_sel = S_PASSA;   // 5, 6 and 7 all pass A
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slice drive: purely a function of the current state and captured request,
  // so the slice response settles within the cycle and is sampled at its end.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case; a path that leaves one unassigned would infer a latch.
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    alu_s  = 4'h0;
    alu_m  = 1'b0;
    alu_ci = 1'b0;
    case (state_q)
      ST_LO: begin
        alu_a  = a_q[3:0];
        alu_b  = b_q[3:0];
        alu_s  = op_sel;
        alu_m  = is_arith;
        alu_ci = ci_q;
      end
      ST_LOADJ: begin
        alu_a  = r_q[3:0];
        alu_b  = 4'h6;
        alu_s  = S_ADD;
        alu_m  = 1'b1;
        alu_ci = 1'b0;
      end
      ST_HI: begin
        alu_a  = a_q[7:4];
        alu_b  = b_q[7:4];
        alu_s  = op_sel;
        alu_m  = is_arith;
        alu_ci = c_lo_q;
      end
      ST_HIADJ: begin
        alu_a  = r_q[7:4];
        alu_b  = 4'h6;
        alu_s  = S_ADD;
        alu_m  = 1'b1;
        alu_ci = 1'b0;
      end
      default: ;   // IDLE and DONE leave the slice quiet
    endcase
  end

  // Carry out of the current arithmetic pass, and the decimal-adjust trigger.
  logic slice_c;
  logic nib_gt9;
  logic b7_eff;
  logic v_bin;

  always_comb begin
    slice_c = alu_g | (alu_p & alu_ci);
    nib_gt9 = (alu_f > 4'd9);
    // For SUB the slice adds ~b, so overflow compares against the inverted sign.
    b7_eff  = (op_q == OP_SUB) ? ~b_q[7] : b_q[7];
    v_bin   = is_arith && (a_q[7] == b7_eff) && (alu_f[3] != a_q[7]);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       fin;       // this cycle completes the high nibble
  logic [3:0] fin_hi;
  logic       fin_c;
  logic       fin_v;
  logic [7:0] fin_r;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    op_d     = op_q;
    dec_d    = dec_q;
    r_d      = r_q;
    c_lo_d   = c_lo_q;
    c_hi_d   = c_hi_q;
    v_d      = v_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_out_d  = c_out_q;
    v_out_d  = v_out_q;
    n_out_d  = n_out_q;
    z_out_d  = z_out_q;
    fin      = 1'b0;
    fin_hi   = 4'h0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ci_d    = ci;
          op_d    = op;
          dec_d   = dec;
          busy_d  = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        r_d[3:0] = alu_f;
        c_lo_d   = slice_c;
        state_d  = (is_dec_add && (slice_c || nib_gt9)) ? ST_LOADJ : ST_HI;
      end
      ST_LOADJ: begin
        r_d[3:0] = alu_f;
        c_lo_d   = 1'b1;   // a decimal adjust always carries into the tens digit
        state_d  = ST_HI;
      end
      ST_HI: begin
        r_d[7:4] = alu_f;
        c_hi_d   = slice_c;
        v_d      = v_bin;
        if (is_dec_add && (slice_c || nib_gt9)) begin
          state_d = ST_HIADJ;
        end else begin
          state_d = ST_DONE;
          fin     = 1'b1;
          fin_hi  = alu_f;
          fin_c   = slice_c;
          fin_v   = v_bin;
        end
      end
      ST_HIADJ: begin
        r_d[7:4] = alu_f;
        c_hi_d   = 1'b1;
        state_d  = ST_DONE;
        fin      = 1'b1;
        fin_hi   = alu_f;
        fin_c    = 1'b1;
        fin_v    = v_q;    // V reflects the binary high pass, not the adjust
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Output registers load on the edge into DONE so that result and flags
    // are valid in the same cycle that done is high.
    fin_r = {fin_hi, r_q[3:0]};
    if (fin) begin
      done_d   = 1'b1;
      result_d = fin_r;
      c_out_d  = is_arith ? fin_c : ci_q;
      v_out_d  = fin_v;
      n_out_d  = fin_r[7];
      z_out_d  = (fin_r == 8'h00);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      ci_q     <= 1'b0;
      op_q     <= 3'd0;
      dec_q    <= 1'b0;
      r_q      <= 8'h00;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      c_out_q  <= 1'b0;
      v_out_q  <= 1'b0;
      n_out_q  <= 1'b0;
      z_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      op_q     <= op_d;
      dec_q    <= dec_d;
      r_q      <= r_d;
      c_lo_q   <= c_lo_d;
      c_hi_q   <= c_hi_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      v_out_q  <= v_out_d;
      n_out_q  <= n_out_d;
      z_out_q  <= z_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign v_out  = v_out_q;
  assign n_out  = n_out_q;
  assign z_out  = z_out_q;

endmodule

// File: tb/tb_alu_seq8.sv
// -----------------------------------------------------------------------------
// tb_alu_seq8 -- self-checking bench for alu_seq8.
//
// Provides a behavioural alu4 slice on the alu_* bus, drives directed and
// random requests, and compares result, flags and done latency against a
// byte/digit-level reference model of the 6502 ALU operations.
// -----------------------------------------------------------------------------
module tb_alu_seq8;

  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic [3:0] S_SUB   = 4'b0110;
  localparam logic [3:0] S_AND   = 4'b1011;
  localparam logic [3:0] S_OR    = 4'b1110;
  localparam logic [3:0] S_XOR   = 4'b0110;
  localparam logic [3:0] S_PASSA = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic       dec;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       c_out;
  logic       v_out;
  logic       n_out;
  logic       z_out;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_ci;
  logic [3:0] alu_f;
  logic       alu_g;
  logic       alu_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq8 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .dec    (dec),
    .a      (a),
    .b      (b),
    .ci     (ci),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .v_out  (v_out),
    .n_out  (n_out),
    .z_out  (z_out),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_s  (alu_s),
    .alu_m  (alu_m),
    .alu_ci (alu_ci),
    .alu_f  (alu_f),
    .alu_g  (alu_g),
    .alu_p  (alu_p)
  );

  // Behavioural alu4 slice.
  logic [3:0] sl_b;
  logic [4:0] sl_sum;

  always_comb begin
    sl_b   = (alu_m && alu_s == S_SUB) ? ~alu_b : alu_b;
    sl_sum = {1'b0, alu_a} + {1'b0, sl_b};
    alu_g  = sl_sum[4];
    alu_p  = &(alu_a ^ sl_b);
    alu_f  = 4'h0;
    if (alu_m) begin
      alu_f = alu_a + sl_b + {3'b000, alu_ci};
    end else begin
      case (alu_s)
        S_AND:   alu_f = alu_a & alu_b;
        S_OR:    alu_f = alu_a | alu_b;
        S_XOR:   alu_f = alu_a ^ alu_b;
        S_PASSA: alu_f = alu_a;
        default: alu_f = 4'h0;
      endcase
    end
  end

  // Reference model: whole-byte arithmetic for binary ops, digit arithmetic
  // for decimal ADD, plus the expected done latency.
  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
    logic [3:0] cyc;
  } exp_t;

  function automatic exp_t model(input logic [2:0] o, input logic d,
                                 input logic [7:0] xa, input logic [7:0] xb,
                                 input logic xc);
    exp_t       e;
    logic [7:0] bb;
    int         lo;
    int         hi;
    int         sum;
    e     = '0;
    e.cyc = 4'd3;
    bb    = (o == 3'd1) ? ~xb : xb;
    case (o)
      3'd0, 3'd1: begin
        if (d && o == 3'd0) begin
          lo = int'(xa[3:0]) + int'(bb[3:0]) + int'(xc);
          if (lo > 9) begin
            lo    = lo + 6;
            e.cyc = e.cyc + 4'd1;
          end
          hi  = int'(xa[7:4]) + int'(bb[7:4]) + ((lo > 15) ? 1 : 0);
          e.v = (xa[7] == bb[7]) && (((hi >> 3) & 1) != int'(xa[7]));
          if (hi > 9) begin
            hi    = hi + 6;
            e.cyc = e.cyc + 4'd1;
          end
          e.c = (hi > 15);
          e.r = 8'((hi % 16) * 16 + (lo % 16));
        end else begin
          sum = int'(xa) + int'(bb) + int'(xc);
          e.r = 8'(sum);
          e.c = (sum > 255);
          e.v = (xa[7] == bb[7]) && (e.r[7] != xa[7]);
        end
      end
      3'd2:    begin e.r = xa & xb; e.c = xc; end
      3'd3:    begin e.r = xa | xb; e.c = xc; end
      3'd4:    begin e.r = xa ^ xb; e.c = xc; end
      default: begin e.r = xa;      e.c = xc; end
    endcase
    e.n = e.r[7];
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  logic seen_m;

  // One complete request: accept, wait for done (bounded), check outputs.
  task automatic run_op(input string tag, input logic [2:0] xo, input logic xd,
                        input logic [7:0] xa, input logic [7:0] xb, input logic xc);
    exp_t e;
    int   k;
    e = model(xo, xd, xa, xb, xc);
    @(negedge clk);
    op = xo; dec = xd; a = xa; b = xb; ci = xc; start = 1'b1;
    @(posedge clk);            // accept edge
    @(negedge clk);            // cycle 1
    start  = 1'b0;
    k      = 1;
    seen_m = alu_m;
    while (!done && k < 12) begin
      @(negedge clk);
      k++;
      seen_m = seen_m | alu_m;
    end
    check({tag, " done_cycle"}, 32'(k), 32'(e.cyc));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    check({tag, " result"}, 32'(result), 32'(e.r));
    check({tag, " c"}, 32'(c_out), 32'(e.c));
    check({tag, " v"}, 32'(v_out), 32'(e.v));
    check({tag, " n"}, 32'(n_out), 32'(e.n));
    check({tag, " z"}, 32'(z_out), 32'(e.z));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    check({tag, " held"}, 32'(result), 32'(e.r));
  endtask

  exp_t   eh;
  int     pulses;
  int     first_k;
  logic [7:0] first_r;
  logic [15:0] mask;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; dec = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst flags", 32'({c_out, v_out, n_out, z_out}), 32'd0);
    check("idle drive", 32'({alu_a, alu_b, alu_s, alu_m, alu_ci}), 32'd0);
    rst = 1'b0;

    // Directed operations
    run_op("add_bin", 3'd0, 1'b0, 8'h3A, 8'h47, 1'b0);
    run_op("sub_4f", 3'd1, 1'b0, 8'h50, 8'h01, 1'b1);
    run_op("sub_ff", 3'd1, 1'b0, 8'h00, 8'h01, 1'b1);
    run_op("dadd_47", 3'd0, 1'b1, 8'h19, 8'h28, 1'b0);
    run_op("dadd_100", 3'd0, 1'b1, 8'h99, 8'h01, 1'b0);
    run_op("and", 3'd2, 1'b0, 8'hF0, 8'h3C, 1'b1);
    check("and m_low", 32'(seen_m), 32'd0);
    run_op("xor", 3'd4, 1'b0, 8'hFF, 8'hFF, 1'b0);
    run_op("or", 3'd3, 1'b0, 8'h0A, 8'h50, 1'b0);
    run_op("op7", 3'd7, 1'b0, 8'hA5, 8'h3C, 1'b1);
    run_op("dsub_bin", 3'd1, 1'b1, 8'h19, 8'h28, 1'b1);

    // Starts during an operation are ignored; operand changes have no effect.
    eh = model(3'd1, 1'b1, 8'h50, 8'h01, 1'b1);
    @(negedge clk);
    op = 3'd1; dec = 1'b1; a = 8'h50; b = 8'h01; ci = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 3'd0; dec = 1'b0; a = 8'h11; b = 8'h22; ci = 1'b0;
    pulses = 0; first_k = 0; first_r = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          first_k = k;
          first_r = result;
        end
      end
      @(negedge clk);
    end
    check("hs pulses", 32'(pulses), 32'd1);
    check("hs done_cycle", 32'(first_k), 32'd3);
    check("hs result", 32'(first_r), 32'(eh.r));
    check("hs c", 32'(c_out), 32'(eh.c));

    // start held high through DONE: next accept in the following IDLE cycle.
    eh = model(3'd0, 1'b0, 8'h3A, 8'h47, 1'b0);
    op = 3'd0; dec = 1'b0; a = 8'h3A; b = 8'h47; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mask = 16'h0000;
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) start = 1'b0;
      if (done) mask[k] = 1'b1;
      @(negedge clk);
    end
    check("b2b done_mask", 32'(mask), 32'h0088);
    check("b2b result", 32'(result), 32'(eh.r));

    // Reset during the high-nibble pass aborts without a done pulse.
    op = 3'd0; dec = 1'b0; a = 8'h19; b = 8'h28; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);            // cycle 1, LO
    start = 1'b0;
    @(negedge clk);            // cycle 2, HI
    check("abort hi_drive", 32'({alu_a, alu_b}), 32'h12);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    check("abort quiet", 32'(pulses), 32'd0);
    run_op("after_abort", 3'd0, 1'b1, 8'h45, 8'h38, 1'b1);

    // Random requests against the model
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
